msu_in_unpacker: RTL and testbench
==================================

# msu_in_unpacker

Unpacks the host-to-MSU AXI-stream frame into the parallel operands of the modular squaring core. Each frame carries t_start, t_final and the nonredundant coefficients of y. The block sits directly upstream of the squaring datapath inside the MSU. It accepts 32-bit beats, checks frame length against `tlast`, and presents zero-extended redundant-form coefficients with a valid/ready handshake.

## Interface
- NONREDUNDANT_ELEMENTS, 8: coefficients carried in a frame
- REDUNDANT_ELEMENTS, 2: extra high coefficients, always loaded as zero
- NUM_ELEMENTS, NONREDUNDANT_ELEMENTS+REDUNDANT_ELEMENTS: output coefficient count
- WORD_LEN, 16: coefficient width on the wire
- BIT_LEN, WORD_LEN+1: coefficient width at the output
- T_LEN, 64: iteration counter width
- AXI_LEN, 32: stream data width
- IN_XFERS, 2*T_LEN/AXI_LEN+(NONREDUNDANT_ELEMENTS+1)/2: beats per frame (8 at defaults)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&&tready
- s_axis_tdata  in  AXI_LEN  beat payload
- s_axis_tlast  in  1  final beat of frame
- s_axis_xfer_size_in_bytes  out  32  constant IN_XFERS*AXI_LEN/8 (32 at defaults)
- t_start  out  T_LEN  starting iteration
- t_final  out  T_LEN  final iteration
- sq_in  out  NUM_ELEMENTS x BIT_LEN  coefficient array
- out_valid  out  1  operands complete and stable
- out_ready  in  1  core consumes operands
- frame_err  out  1  one-cycle pulse on length/tlast mismatch

## Operation
- Beat order, little-endian:
  - Beat 0: t_start[31:0].
  - Beat 1: t_start[63:32].
  - Beats 2-3: t_final, same layout.
  - Beat 4+j: element 2j in [15:0], element 2j+1 in [31:16].
- General beat layout: beat index b < T_LEN/AXI_LEN loads t_start; the next T_LEN/AXI_LEN beats load t_final; the rest load y.
- Coefficients are zero-extended from WORD_LEN to BIT_LEN.
- Elements at index >= NONREDUNDANT_ELEMENTS are forced to 0. For odd NONREDUNDANT_ELEMENTS, the upper half of the last beat is discarded.
- Beat counter: clog2(IN_XFERS+1) bits, increments on each accepted beat, cleared at frame end.
- FSM states:
  - RECV: tready=1. Each accepted beat is written at the counter position.
    - Accepted beat with count==IN_XFERS-1 and tlast=1: go to DONE.
    - Accepted beat with count==IN_XFERS-1 and tlast=0: pulse frame_err, go to DRAIN.
    - Accepted beat with tlast=1 and count<IN_XFERS-1 (early): pulse frame_err, clear counter, stay in RECV.
  - DRAIN: tready=1, beats discarded. On an accepted beat with tlast=1, clear counter and go to RECV.
  - DONE: tready=0, out_valid=1, outputs frozen. When out_ready=1, go to RECV with counter cleared.
- An errored frame never produces out_valid. Registers partially overwritten by an errored frame are only guaranteed correct after the next good frame completes.

## Timing
- Reset (async assert, synchronous deassert handled upstream) sets:
  - state=RECV, counter=0, out_valid=0, frame_err=0, t_start=0, t_final=0, all sq_in=0.
  - s_axis_tready=1 from the first cycle after reset release.
- Latency: out_valid rises the cycle after the final beat handshake. A full frame takes IN_XFERS+1 cycles minimum at tvalid=1.
- out_valid stays high until the cycle out_ready=1 is sampled; it is low the following cycle.
- tready returns high in that same following cycle, so back-to-back frames incur one bubble.
- frame_err is high for exactly one cycle, the cycle after the offending beat handshake.
- tvalid gaps in RECV or DRAIN: counter holds, no state change.
- out_ready while out_valid=0: ignored.
- reset_n low mid-frame or in DONE: immediate return to reset values; the partial frame is lost.

## Test plan
- Nominal frame, defaults:
  - Stimulus: 8 beats 0x00000005, 0, 0x00000064, 0, 0x00020001, 0x00040003, 0x00060005, 0x00080007 with tlast on beat 7.
  - Response: out_valid one cycle after beat 7; t_start=5, t_final=100; sq_in[0..7]=1..8, sq_in[8]=sq_in[9]=0; s_axis_xfer_size_in_bytes=32.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after the frame.
  - Response: tready=0 and outputs unchanged throughout. After out_ready=1, out_valid falls and tready rises next cycle. A second frame is then accepted correctly.
- Early tlast:
  - Stimulus: tlast on beat 3.
  - Response: frame_err single pulse, no out_valid. The following good frame loads correctly.
- Missing tlast:
  - Stimulus: 8 beats without tlast, then 3 more beats with tlast on the last.
  - Response: frame_err pulse after beat 7; extra beats dropped; no out_valid; next good frame correct.
- Random tvalid gaps (50% duty) plus coefficient 0xFFFF:
  - Response: sq_in element = 17'h0FFFF, ordering identical to the nominal frame.
- reset_n asserted after beat 5:
  - Response: all outputs at reset values asynchronously. A fresh full frame after release loads correctly with no frame_err.

Source files
------------

// File: rtl/msu_in_unpacker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : msu_in_unpacker
// Brief    : Unpacks a host AXI-stream frame into t_start, t_final and
//            zero-extended redundant-form coefficients for the squaring core.
// Revision : 1.0 - initial release
// ============================================================================
module msu_in_unpacker #(
    parameter int NONREDUNDANT_ELEMENTS = 8,
    parameter int REDUNDANT_ELEMENTS    = 2,
    parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
    parameter int WORD_LEN              = 16,
    parameter int BIT_LEN               = WORD_LEN + 1,
    parameter int T_LEN                 = 64,
    parameter int AXI_LEN               = 32,
    parameter int IN_XFERS              = 2*T_LEN/AXI_LEN + (NONREDUNDANT_ELEMENTS+1)/2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic [AXI_LEN-1:0]                     s_axis_tdata,
    input  logic                                   s_axis_tlast,
    output logic [31:0]                            s_axis_xfer_size_in_bytes,
    output logic [T_LEN-1:0]                       t_start,
    output logic [T_LEN-1:0]                       t_final,
    output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   sq_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   frame_err
);

    localparam int c_CW  = $clog2(IN_XFERS + 1);
    localparam int c_TPB = T_LEN / AXI_LEN;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(IN_XFERS - 1);

    localparam logic [1:0] c_RECV  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]                         r_state;
    logic [c_CW-1:0]                    r_cnt;
    logic [T_LEN-1:0]                   r_t_start;
    logic [T_LEN-1:0]                   r_t_final;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] r_sq;
    logic                               r_out_valid;
    logic                               r_frame_err;
    logic                               w_hs;

    assign s_axis_tready             = (r_state != c_DONE);
    assign w_hs                      = s_axis_tvalid && s_axis_tready;
    assign s_axis_xfer_size_in_bytes = 32'(IN_XFERS * AXI_LEN / 8);
    assign t_start                   = r_t_start;
    assign t_final                   = r_t_final;
    assign sq_in                     = r_sq;
    assign out_valid                 = r_out_valid;
    assign frame_err                 = r_frame_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_RECV;
            r_cnt       <= '0;
            r_t_start   <= '0;
            r_t_final   <= '0;
            r_sq        <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_RECV: begin
                    if (w_hs) begin
                        for (int k = 0; k < c_TPB; k++) begin
                            if (r_cnt == c_CW'(k))
                                r_t_start[k*AXI_LEN +: AXI_LEN] <= s_axis_tdata;
                            if (r_cnt == c_CW'(c_TPB + k))
                                r_t_final[k*AXI_LEN +: AXI_LEN] <= s_axis_tdata;
                        end
                        // Redundant elements are never written, so they hold zero.
                        for (int e = 0; e < NONREDUNDANT_ELEMENTS; e++) begin
                            if (r_cnt == c_CW'(2*c_TPB + e/2))
                                r_sq[e] <= BIT_LEN'(s_axis_tdata[(e%2)*WORD_LEN +: WORD_LEN]);
                        end
                        if (r_cnt == c_LAST) begin
                            r_cnt <= '0;
                            if (s_axis_tlast) begin
                                r_state     <= c_DONE;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= c_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            r_frame_err <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_hs && s_axis_tlast) begin
                        r_state <= c_RECV;
                        r_cnt   <= '0;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state     <= c_RECV;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: r_state <= c_RECV;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msu_in_unpacker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_msu_in_unpacker
// Brief    : Scoreboard bench for msu_in_unpacker frame unpacking and errors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msu_in_unpacker;

    localparam int NUM_ELEMENTS = 10;
    localparam int BIT_LEN      = 17;

    typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] sq_t;
    typedef struct {
        logic [63:0] ts;
        logic [63:0] tf;
        sq_t         sq;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        out_ready = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_xfer_size_in_bytes;
    logic [63:0] t_start;
    logic [63:0] t_final;
    sq_t         sq_in;
    logic        out_valid;
    logic        frame_err;

    int          errors = 0;
    int          checks = 0;
    int          err_pulses = 0;
    logic [31:0] beats [0:15];
    exp_t        exp_q [$];

    msu_in_unpacker dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .s_axis_tvalid             (s_axis_tvalid),
        .s_axis_tready             (s_axis_tready),
        .s_axis_tdata              (s_axis_tdata),
        .s_axis_tlast              (s_axis_tlast),
        .s_axis_xfer_size_in_bytes (s_axis_xfer_size_in_bytes),
        .t_start                   (t_start),
        .t_final                   (t_final),
        .sq_in                     (sq_in),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .frame_err                 (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) err_pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic fill_random();
        for (int i = 0; i < 8; i++) beats[i] = $urandom;
    endtask

    task automatic push_exp();
        exp_t x;
        x.ts = {beats[1], beats[0]};
        x.tf = {beats[3], beats[2]};
        x.sq = '0;
        for (int e = 0; e < 8; e++)
            x.sq[e] = (e % 2 == 1) ? {1'b0, beats[4 + e/2][31:16]} : {1'b0, beats[4 + e/2][15:0]};
        exp_q.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge following the last handshake.
    task automatic send(input int n, input int last_idx, input bit gaps);
        bit hs;
        for (int i = 0; i < n; i++) begin
            if (gaps)
                for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beats[i];
            s_axis_tlast  = (i == last_idx);
            hs = 1'b0;
            for (int k = 0; k < 20 && !hs; k++) begin
                hs = s_axis_tready;
                @(negedge clk);
            end
            checks++;
            if (!hs) begin
                errors++;
                $display("FAIL handshake beat %0d: tready=0 required 1", i);
            end
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b want 1", s_axis_tready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
        checks++; if (t_start !== 64'd0 || t_final !== 64'd0) begin errors++; $display("FAIL rst_t: got %h/%h want 0", t_start, t_final); end
        checks++; if (sq_in !== '0) begin errors++; $display("FAIL rst_sq_in: got %h want 0", sq_in); end
        checks++; if (s_axis_xfer_size_in_bytes !== 32'd32) begin errors++; $display("FAIL xfer_size: got %0d want 32", s_axis_xfer_size_in_bytes); end
    endtask

    task automatic test_nominal();
        exp_t x;
        beats[0] = 32'h5; beats[1] = 32'h0; beats[2] = 32'h64; beats[3] = 32'h0;
        beats[4] = 32'h0002_0001; beats[5] = 32'h0004_0003;
        beats[6] = 32'h0006_0005; beats[7] = 32'h0008_0007;
        push_exp();
        send(8, 7, 1'b0);
        x = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nom_out_valid: got %b want 1", out_valid); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL nom_tready: got %b want 0", s_axis_tready); end
        checks++; if (t_start !== x.ts) begin errors++; $display("FAIL nom_t_start: got %h want %h", t_start, x.ts); end
        checks++; if (t_final !== 64'd100) begin errors++; $display("FAIL nom_t_final: got %h want 64", t_final); end
        checks++; if (sq_in !== x.sq) begin errors++; $display("FAIL nom_sq_in: got %h want %h", sq_in, x.sq); end
        checks++; if (sq_in[7] !== 17'd8 || sq_in[8] !== 17'd0 || sq_in[9] !== 17'd0) begin
            errors++; $display("FAIL nom_sq_edges: got %h %h %h want 8 0 0", sq_in[7], sq_in[8], sq_in[9]); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL nom_frame_err: got %b want 0", frame_err); end
        consume();
    endtask

    task automatic test_backpressure();
        exp_t x;
        fill_random();
        push_exp();
        send(8, 7, 1'b0);
        x = exp_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || s_axis_tready !== 1'b0 || t_start !== x.ts || t_final !== x.tf || sq_in !== x.sq) begin
                errors++;
                $display("FAIL bp_hold cyc %0d: valid=%b tready=%b t_start=%h want valid=1 tready=0 t_start=%h", c, out_valid, s_axis_tready, t_start, x.ts);
            end
            @(negedge clk);
        end
        consume();
        checks++; if (out_valid !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL bp_release: valid=%b tready=%b want 0 1", out_valid, s_axis_tready); end
        fill_random();
        push_exp();
        send(8, 7, 1'b0);
        x = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || t_start !== x.ts || t_final !== x.tf || sq_in !== x.sq) begin
            errors++; $display("FAIL bp_second: valid=%b t_start=%h sq=%h want 1 %h %h", out_valid, t_start, sq_in, x.ts, x.sq); end
        consume();
    endtask

    task automatic test_early_tlast();
        exp_t x;
        int e0;
        e0 = err_pulses;
        fill_random();
        send(4, 3, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_err: got %b want 1", frame_err); end
        @(negedge clk);
        checks++; if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL early_after: err=%b valid=%b want 0 0", frame_err, out_valid); end
        fill_random();
        push_exp();
        send(8, 7, 1'b0);
        x = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || t_start !== x.ts || t_final !== x.tf || sq_in !== x.sq) begin
            errors++; $display("FAIL early_next: valid=%b t_start=%h sq=%h want 1 %h %h", out_valid, t_start, sq_in, x.ts, x.sq); end
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL early_pulses: got %0d want 1", err_pulses - e0); end
        consume();
    endtask

    task automatic test_missing_tlast();
        exp_t x;
        int e0;
        e0 = err_pulses;
        fill_random();
        send(8, -1, 1'b0);
        checks++; if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL miss_err: err=%b valid=%b want 1 0", frame_err, out_valid); end
        send(3, 2, 1'b0);
        checks++; if (out_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL miss_drain: valid=%b err=%b want 0 0", out_valid, frame_err); end
        fill_random();
        push_exp();
        send(8, 7, 1'b0);
        x = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || t_start !== x.ts || t_final !== x.tf || sq_in !== x.sq) begin
            errors++; $display("FAIL miss_next: valid=%b t_start=%h sq=%h want 1 %h %h", out_valid, t_start, sq_in, x.ts, x.sq); end
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL miss_pulses: got %0d want 1", err_pulses - e0); end
        consume();
    endtask

    task automatic test_gaps_ffff();
        exp_t x;
        fill_random();
        beats[4] = 32'hFFFF_FFFF;
        beats[7] = 32'h0000_FFFF;
        push_exp();
        send(8, 7, 1'b1);
        x = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || t_start !== x.ts || t_final !== x.tf || sq_in !== x.sq) begin
            errors++; $display("FAIL gaps_frame: valid=%b t_start=%h sq=%h want 1 %h %h", out_valid, t_start, sq_in, x.ts, x.sq); end
        checks++; if (sq_in[0] !== 17'h0FFFF || sq_in[6] !== 17'h0FFFF || sq_in[7] !== 17'h0) begin
            errors++; $display("FAIL gaps_ffff: got %h %h %h want 0ffff 0ffff 0", sq_in[0], sq_in[6], sq_in[7]); end
        consume();
    endtask

    task automatic test_reset_midframe();
        exp_t x;
        int e0;
        fill_random();
        beats[0] = beats[0] | 32'h1;
        send(6, -1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (t_start !== 64'd0 || t_final !== 64'd0 || sq_in !== '0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL mid_reset: t_start=%h valid=%b want 0 0", t_start, out_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL mid_rst_tready: got %b want 1", s_axis_tready); end
        e0 = err_pulses;
        fill_random();
        push_exp();
        send(8, 7, 1'b0);
        x = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || t_start !== x.ts || t_final !== x.tf || sq_in !== x.sq) begin
            errors++; $display("FAIL mid_next: valid=%b t_start=%h sq=%h want 1 %h %h", out_valid, t_start, sq_in, x.ts, x.sq); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL mid_pulses: got %0d want 0", err_pulses - e0); end
        consume();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_tlast();
        test_missing_tlast();
        test_gaps_ffff();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
